// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, GF(2^8) helpers, Rcon, FSM state type and key-length check.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} aes_state_t;

  // Row-major FIPS-197 S-box; entry 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TABLE[{~a, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_in[127-8*i -: 8]);
  end

  // Byte 4*c+r is row r of column c; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
    assign mc[4*c+0] = mul2(sr[4*c]) ^ mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c] ^ mul2(sr[4*c+1]) ^ mul3(sr[4*c+2]) ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ mul2(sr[4*c+2]) ^ mul3(sr[4*c+3]);
    assign mc[4*c+3] = mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ mul2(sr[4*c+3]);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_out[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: key expanded once per load, then one round per clock.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter  int NK = 4,
  localparam int NR = NK + 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [32*NK-1:0] key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data
);

  localparam int         NW     = 4 * (NR + 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_W = 6'(NW - 1);
  localparam logic [3:0] NR_W   = 4'(NR);

  if (!nk_legal(NK)) begin : g_bad_nk
    $error("aes_encrypt_iter: NK must be 4, 6 or 8");
  end

  aes_state_t   state, state_next;
  logic         key_loaded;
  logic         key_load, accept;
  logic [3:0]   rnd;
  logic [5:0]   widx;
  logic [127:0] st;
  logic [31:0]  w [NW];
  logic [31:0]  prev_word, temp_word, new_word;
  logic [5:0]   kmod;
  logic [5:0]   rbase;
  logic [127:0] rk0, round_key, round_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A key request in IDLE always beats a pending plaintext.
  always_comb begin
    state_next = state;
    key_load   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          key_load   = 1'b1;
          state_next = KEYEXP;
        end else if (in_valid && key_loaded) begin
          accept     = 1'b1;
          state_next = ROUND;
        end
      end
      KEYEXP:  if (widx == LAST_W) state_next = IDLE;
      ROUND:   if (rnd == NR_W) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign key_ready = (state == IDLE);
  assign in_ready  = (state == IDLE) && key_loaded;

  always_comb begin
    prev_word = w[widx - 6'd1];
    kmod      = widx % NK_W;
    temp_word = prev_word;
    if (kmod == 6'd0)
      temp_word = sub_word(rot_word(prev_word)) ^ {rcon(4'(widx / NK_W)), 24'h000000};
    else if (NK == 8 && kmod == 6'd4)
      temp_word = sub_word(prev_word);
    new_word = w[widx - NK_W] ^ temp_word;
  end

  // Key words only come from a load, later words only from expansion; the store is never reset.
  for (genvar j = 0; j < NW; j++) begin : g_store
    if (j < NK) begin : g_key
      always_ff @(posedge clk)
        if (!rst && key_load) w[j] <= key[32*(NK-1-j) +: 32];
    end else begin : g_exp
      always_ff @(posedge clk)
        if (!rst && state == KEYEXP && widx == 6'(j)) w[j] <= new_word;
    end
  end

  assign rk0       = {w[0], w[1], w[2], w[3]};
  assign rbase     = {rnd, 2'b00};
  assign round_key = {w[rbase], w[rbase + 6'd1], w[rbase + 6'd2], w[rbase + 6'd3]};

  aes_round_comb u_round (
    .state_in    (st),
    .round_key   (round_key),
    .final_round (rnd == NR_W),
    .state_out   (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      st         <= '0;
      rnd        <= '0;
      widx       <= '0;
    end else begin
      if (key_load) begin
        key_loaded <= 1'b0;
        widx       <= NK_W;
      end
      if (accept) begin
        st  <= in_data ^ rk0;
        rnd <= 4'd1;
      end
      if (state == KEYEXP) begin
        widx <= widx + 6'd1;
        if (widx == LAST_W) key_loaded <= 1'b1;
      end
      if (state == ROUND) begin
        if (rnd == NR_W) begin
          out_data  <= round_out;
          out_valid <= 1'b1;
        end else begin
          st  <= round_out;
          rnd <= rnd + 4'd1;
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors, handshake timing, backpressure, reset aborts.
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         key_valid, key_ready, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key, in_data, out_data;

  logic         key_valid6, key_ready6, in_valid6, in_ready6, out_valid6;
  logic [191:0] key6;
  logic [127:0] out_data6;
  logic         key_valid8, key_ready8, in_valid8, in_ready8, out_valid8;
  logic [255:0] key8;
  logic [127:0] out_data8;
  logic [127:0] in_data_w;
  logic         out_ready_w;

  aes_encrypt_iter #(.NK(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  aes_encrypt_iter #(.NK(6)) dut6 (
    .clk(clk), .rst(rst), .key_valid(key_valid6), .key_ready(key_ready6), .key(key6),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data_w),
    .out_valid(out_valid6), .out_ready(out_ready_w), .out_data(out_data6)
  );

  aes_encrypt_iter #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .key_valid(key_valid8), .key_ready(key_ready8), .key(key8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data_w),
    .out_valid(out_valid8), .out_ready(out_ready_w), .out_data(out_data8)
  );

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] SEQ_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] SEQ_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return key_ready;
      1: return in_ready;
      2: return out_valid;
      3: return key_ready6;
      4: return out_valid6;
      5: return key_ready8;
      default: return out_valid8;
    endcase
  endfunction

  // Waits (bounded) for a signal to go high, then checks it really did.
  task automatic waitHigh(input string tag, input int which, input int bound);
    int n;
    n = 0;
    while (sig(which) !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 128'(sig(which)), 128'd1);
  endtask

  task automatic loadKey(input logic [127:0] k, input logic with_block, output int low_cycles,
                         output logic stray);
    waitHigh("key_ready_before_load", 0, 100);
    key = k; key_valid = 1'b1; in_data = FIPS_PT; in_valid = with_block;
    @(negedge clk);
    key_valid = 1'b0; in_valid = 1'b0;
    low_cycles = 0;
    stray = 1'b0;
    while (key_ready !== 1'b1 && low_cycles < 200) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) stray = 1'b1;
      low_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct);
    int c0;
    waitHigh({tag, "_in_ready"}, 1, 100);
    in_data = pt; in_valid = 1'b1; c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, "_in_ready_busy"}, 128'(in_ready), 128'd0);
    waitHigh({tag, "_out_valid"}, 2, 40);
    checkOutput({tag, "_latency"}, 128'(cyc - c0), 128'd11);
    checkOutput({tag, "_data"}, out_data, exp_ct);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_cleared"}, 128'(out_valid), 128'd0);
    checkOutput({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
  endtask

  task automatic runWide(input int nk, input logic [127:0] exp_ct);
    int k0, c0, low;
    int kr_sel, ov_sel;
    kr_sel = (nk == 6) ? 3 : 5;
    ov_sel = (nk == 6) ? 4 : 6;
    waitHigh($sformatf("nk%0d_key_ready", nk), kr_sel, 10);
    if (nk == 6) begin key6 = SEQ_KEY[255:64]; key_valid6 = 1'b1; end
    else         begin key8 = SEQ_KEY;         key_valid8 = 1'b1; end
    k0 = cyc;
    @(negedge clk);
    key_valid6 = 1'b0; key_valid8 = 1'b0;
    low = 0;
    while (sig(kr_sel) !== 1'b1 && low < 200) begin
      low++;
      @(negedge clk);
    end
    checkOutput($sformatf("nk%0d_keyexp_cycles", nk), 128'(low), 128'(4 * (nk + 7) - nk));
    in_data_w = SEQ_PT;
    if (nk == 6) in_valid6 = 1'b1; else in_valid8 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    in_valid6 = 1'b0; in_valid8 = 1'b0;
    waitHigh($sformatf("nk%0d_out_valid", nk), ov_sel, 40);
    checkOutput($sformatf("nk%0d_latency", nk), 128'(cyc - c0), 128'(nk + 7));
    checkOutput($sformatf("nk%0d_data", nk), (nk == 6) ? out_data6 : out_data8, exp_ct);
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
    checkOutput($sformatf("nk%0d_out_valid_cleared", nk), 128'(sig(ov_sel)), 128'd0);
    if (k0 < 0) $display("[TB] unreachable");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low;
    logic stray, ok;
    logic [127:0] held;

    rst = 1'b1;
    key_valid = 0; in_valid = 0; out_ready = 0; key = '0; in_data = '0;
    key_valid6 = 0; in_valid6 = 0; key8 = '0; key6 = '0;
    key_valid8 = 0; in_valid8 = 0; in_data_w = '0; out_ready_w = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_key_ready", 128'(key_ready), 128'd1);
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_out_data", out_data, 128'd0);

    $display("[TB] plaintext before any key");
    in_data = FIPS_PT; in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || key_ready !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
    end
    in_valid = 1'b0;
    checkOutput("no_key_block_ignored", 128'(ok), 128'd1);

    $display("[TB] FIPS-197 AES-128 key load and encrypt");
    loadKey(FIPS_KEY, 1'b0, low, stray);
    checkOutput("fips_keyexp_cycles", 128'(low), 128'd40);
    checkOutput("fips_keyexp_quiet", 128'(stray), 128'd0);
    checkOutput("fips_in_ready_loaded", 128'(in_ready), 128'd1);
    applyStimulus("fips_blk1", FIPS_PT, FIPS_CT);
    applyStimulus("fips_blk2", FIPS_PT, FIPS_CT);

    $display("[TB] output backpressure");
    waitHigh("bp_in_ready", 1, 10);
    in_data = FIPS_PT; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitHigh("bp_out_valid", 2, 40);
    held = out_data;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    checkOutput("bp_held_stable", 128'(ok), 128'd1);
    checkOutput("bp_data", out_data, FIPS_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_out_valid_cleared", 128'(out_valid), 128'd0);
    checkOutput("bp_in_ready_after", 128'(in_ready), 128'd1);

    $display("[TB] key and block requested together");
    loadKey(SEQ_KEY[255:128], 1'b1, low, stray);
    checkOutput("reload_keyexp_cycles", 128'(low), 128'd40);
    checkOutput("reload_block_not_taken", 128'(stray), 128'd0);
    checkOutput("reload_in_ready_after", 128'(in_ready), 128'd1);
    applyStimulus("aes128_seq", SEQ_PT, CT128);

    $display("[TB] reset mid-ROUND");
    waitHigh("rr_in_ready", 1, 10);
    in_data = SEQ_PT; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rr_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rr_in_ready", 128'(in_ready), 128'd0);
    checkOutput("rr_key_ready", 128'(key_ready), 128'd1);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
    end
    checkOutput("rr_output_dropped", 128'(ok), 128'd1);

    $display("[TB] reset mid-KEYEXP");
    key = FIPS_KEY; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rk_in_keyexp", 128'(key_ready), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rk_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rk_in_ready", 128'(in_ready), 128'd0);
    checkOutput("rk_key_ready", 128'(key_ready), 128'd1);

    $display("[TB] reload after reset");
    loadKey(FIPS_KEY, 1'b0, low, stray);
    checkOutput("after_rst_keyexp_cycles", 128'(low), 128'd40);
    applyStimulus("after_rst_fips", FIPS_PT, FIPS_CT);

    $display("[TB] AES-192 and AES-256");
    runWide(6, CT192);
    runWide(8, CT256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
# aes_encrypt_iter

Iterative, clocked AES encryptor parametrised for AES-128, AES-192 and AES-256, processing one round per cycle. It expands the key once per key load into an internal round-key store and then encrypts any number of blocks under that key. Blocks enter and leave through valid/ready handshakes. It is the area-lean sequential successor to the fully unrolled combinational encryptor, sitting between a block source (DMA/stream) and a ciphertext sink.

## Interface
- NK, 4, key length in 32-bit words; legal values 4/6/8; any other value is an elaboration error
- NR, NK+6, round count; derived, not overridable
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  key load request
- key_ready  out  1  block can accept a key
- key  in  32*NK  cipher key; first key byte at the MSBs
- in_valid  in  1  plaintext valid
- in_ready  out  1  block can accept plaintext
- in_data  in  128  plaintext; byte 0 at [127:120], column-major as FIPS-197
- out_valid  out  1  ciphertext valid
- out_ready  in  1  sink accepts ciphertext
- out_data  out  128  ciphertext, same byte order as in_data

## Operation
- States: IDLE, KEYEXP, ROUND, DONE.
- Reset behaviour:
  - state=IDLE; key_loaded=0; out_valid=0; out_data=0; key_ready=1; in_ready=0.
  - The round-key store is not cleared.
- Handshake rules:
  - key_ready = (state==IDLE).
  - in_ready = (state==IDLE) && key_loaded.
  - A transfer occurs when valid && ready at a clock edge.
- Key load (IDLE, key_valid):
  - Capture key words w[0..NK-1] into the store; clear key_loaded; go to KEYEXP with word index i=NK.
  - If key_valid and in_valid are both high in the same IDLE cycle, the key wins. in_data is not accepted.
- KEYEXP:
  - Produces one word w[i] per cycle using the standard schedule: RotWord/SubWord/Rcon when i%NK==0, SubWord only when NK==8 && i%NK==4.
  - Rcon index is i/NK, 1..10.
  - After the final word w[4*NR+3] is written, set key_loaded=1 and return to IDLE.
  - Expansion takes 4*(NR+1)-NK cycles: 40, 46 or 52.
- Encrypt:
  - On in_valid && in_ready, st ← in_data ^ rk[0], r ← 1, go to ROUND.
  - Each ROUND cycle applies st ← MixColumns(ShiftRows(SubBytes(st))) ^ rk[r] for r<NR.
  - When r==NR, MixColumns is skipped; out_data ← result, out_valid ← 1, go to DONE.
- DONE:
  - out_data and out_valid hold until out_valid && out_ready; then go to IDLE and clear out_valid.
  - out_data retains its last value.
- Key_loaded persists across blocks. A new key load invalidates it until its expansion completes.
- Reset mid-operation (KEYEXP, ROUND or DONE) aborts everything. Any pending output is dropped; key_loaded=0, so the key must be reloaded.
- Round counter width is 4 bits; word index width is 6 bits. No wrap-around is reachable.

## Timing
- Encrypt latency: accept edge at cycle 0 gives out_valid high after edge NR+1. That is 11, 13 or 15 cycles.
- Throughput: one block per NR+2 cycles minimum, when out_ready is held high (accept, NR rounds, handshake-out).
- in_ready is low from the accept edge until the edge after the output handshake; back-to-back blocks are never overlapped.
- out_valid may be held indefinitely by out_ready=0 without loss or corruption.
- key_ready deasserts the cycle after a key transfer and reasserts the cycle after the last expansion word is written.
- No combinational path from any input to any output.

## Structure
- Package aes_pkg holds:
  - the S-box function
  - the xtime/mul2/mul3 functions
  - the Rcon table
  - the state enum {IDLE, KEYEXP, ROUND, DONE}
  - the legal-NK check
- Sub-module aes_round_comb: combinational SubBytes→ShiftRows→(optional MixColumns)→AddRoundKey.
  - Ports: state_in, round_key, final_round, state_out.
  - Instantiated once, reused every round.
- The round-key store is a 4*(NR+1)×32 register array inside the top.
- The key-schedule word logic shares the S-box function from aes_pkg.

## Test plan
- NK=4: load key 2b7e151628aed2a6abf7158809cf4f3c, encrypt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32; out_valid exactly 11 cycles after accept; key_ready low for 40 cycles.
- NK=4/6/8: key 000102…0f / …17 / …1f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: hold out_ready=0 for 20 cycles → out_data stable, in_ready=0 throughout; release → handshake, then in_ready=1 next cycle.
- Key reuse and reload: two blocks under one key give correct results with no re-expansion; key_valid and in_valid asserted together → key accepted, block not accepted, in_ready=0 until expansion completes.
- Reset mid-ROUND and mid-KEYEXP → next cycle out_valid=0, in_ready=0, key_ready=1; after reload, the FIPS vector is correct again.
- in_valid before any key load → never accepted (in_ready stays 0).
